// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB bridge: FSM state encoding and the
// one-hot slave-select helper used by the address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Widest select vector onehot_dec can build; decoders slice the low bits.
    localparam int MAX_DEC = 64;

    function automatic logic [MAX_DEC-1:0] onehot_dec(input logic [31:0] idx);
        logic [MAX_DEC-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DEC; i++) begin
            v[i] = (idx == 32'(i));
        end
        return v;
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB2-style bus between the bridge and the downstream read-data multiplexor.
// No pready/pslverr: every transfer is a fixed SETUP/ACCESS pair.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEC_NUMBER = 16
) ();

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  penable;
    logic [DEC_NUMBER-1:0] pselx;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;

    modport bridge (
        output paddr, penable, pselx, pwrite, pwdata,
        input  prdata
    );

    modport mux (
        input  paddr, penable, pselx, pwrite, pwdata,
        output prdata
    );

endinterface

// File: rtl/apb_decoder.sv
// Combinational address decoder: selects one of DEC_NUMBER slaves from the
// field addr[DEC_LSB +: log2(DEC_NUMBER)].
module apb_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEC_NUMBER = 16,
    parameter int DEC_LSB    = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DEC_NUMBER-1:0] sel
);

    localparam int DEC_W = $clog2(DEC_NUMBER);

    logic [DEC_W-1:0]   idx;
    logic [MAX_DEC-1:0] full;
    logic               unused_bits;

    assign idx  = addr[DEC_LSB +: DEC_W];
    assign full = onehot_dec(32'(idx));
    assign sel  = full[DEC_NUMBER-1:0];

    // Only the decode field matters; the rest of the address and the unused
    // upper select bits are intentionally dropped.
    assign unused_bits = ^{addr, full};

endmodule

// File: rtl/apb_bridge.sv
// Host valid/ready request channel to APB2 master: fixed SETUP/ACCESS transfer,
// one-hot slave select, read data returned on a valid/ready response channel.
module apb_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEC_NUMBER = 16,
    parameter int DEC_LSB    = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_write_o,
    apb_if.bridge                 apb
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic                  write;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    apb_state_t            state_q, state_d;
    req_t                  req_q;
    rsp_t                  rsp_q;
    logic                  rsp_vld_q;
    logic [DEC_NUMBER-1:0] psel_q;
    logic [DEC_NUMBER-1:0] dec_sel;
    logic                  accept;
    logic                  penable;

    apb_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEC_NUMBER (DEC_NUMBER),
        .DEC_LSB    (DEC_LSB)
    ) u_dec (
        .addr (req_addr_i),
        .sel  (dec_sel)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A held response blocks new requests so the response stays stable.
    always_comb begin
        req_ready_o = (state_q == IDLE) && (!rsp_vld_q || rsp_ready_i);
        accept      = req_valid_i && req_ready_o;
        penable     = (state_q == ACCESS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q     <= '0;
            psel_q    <= '0;
        end else if (accept) begin
            req_q.addr  <= req_addr_i;
            req_q.write <= req_write_i;
            req_q.wdata <= req_wdata_i;
            psel_q      <= dec_sel;
        end else if (state_q == ACCESS) begin
            psel_q      <= '0;
        end
    end

    // A response loaded at ACCESS overrides a same-edge consume.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            rsp_q.write <= req_q.write;
            rsp_q.rdata <= req_q.write ? '0 : apb.prdata;
            rsp_vld_q   <= 1'b1;
        end else if (rsp_vld_q && rsp_ready_i) begin
            rsp_vld_q   <= 1'b0;
        end
    end

    assign apb.paddr   = req_q.addr;
    assign apb.pwrite  = req_q.write;
    assign apb.pwdata  = req_q.wdata;
    assign apb.pselx   = psel_q;
    assign apb.penable = penable;

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_write_o = rsp_q.write;

endmodule

// File: tb/tb_apb_bridge.sv
// Self-checking bench for apb_bridge: directed and random transfers against a
// behavioural model of the SETUP/ACCESS timing and slave read data.
module tb_apb_bridge;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int DN = 16;
    localparam int DL = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_write;

    apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEC_NUMBER(DN)) bus ();

    apb_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEC_NUMBER (DN),
        .DEC_LSB    (DL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_write_o (rsp_write),
        .apb         (bus)
    );

    always #5 clk = ~clk;

    // Slave register contents; the selected slave drives prdata.
    logic [DW-1:0] slv_data [DN];

    always_comb begin
        bus.prdata = '0;
        for (int i = 0; i < DN; i++)
            if (bus.pselx[i]) bus.prdata = slv_data[i];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DN-1:0] exp_sel(input logic [AW-1:0] a);
        logic [DN-1:0] s;
        s = '0;
        s[a[DL +: 4]] = 1'b1;
        return s;
    endfunction

    // One transfer starting at a negedge in IDLE; returns at the negedge
    // after the response edge with req_valid still high.
    task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                        input bit b2b);
        logic [DW-1:0] exp_rd;
        int            acc;
        exp_rd    = wr ? '0 : slv_data[a[DL +: 4]];
        req_valid = 1'b1;
        req_addr  = a;
        req_write = wr;
        req_wdata = wd;
        #1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        acc = cyc;
        if (b2b) check("accept_spacing", 64'(acc - last_acc), 64'd3);
        last_acc = acc;
        @(negedge clk);
        check("setup_pselx",    64'(bus.pselx), 64'(exp_sel(a)));
        check("setup_onehot",   64'($countones(bus.pselx)), 64'd1);
        check("setup_penable",  64'(bus.penable), 64'd0);
        check("setup_paddr",    64'(bus.paddr), 64'(a));
        check("setup_pwrite",   64'(bus.pwrite), 64'(wr));
        check("setup_pwdata",   64'(bus.pwdata), 64'(wd));
        check("setup_req_rdy",  64'(req_ready), 64'd0);
        check("setup_rsp_vld",  64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("access_pselx",   64'(bus.pselx), 64'(exp_sel(a)));
        check("access_penable", 64'(bus.penable), 64'd1);
        check("access_req_rdy", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("rsp_valid",      64'(rsp_valid), 64'd1);
        check("rsp_rdata",      64'(rsp_rdata), 64'(exp_rd));
        check("rsp_write",      64'(rsp_write), 64'(wr));
        check("idle_pselx",     64'(bus.pselx), 64'd0);
        check("idle_penable",   64'(bus.penable), 64'd0);
        check("idle_req_rdy",   64'(req_ready), 64'(rsp_ready));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] bp_data;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < DN; i++) slv_data[i] = {$urandom, $urandom};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pselx",   64'(bus.pselx), 64'd0);
        check("rst_penable", 64'(bus.penable), 64'd0);
        check("rst_paddr",   64'(bus.paddr), 64'd0);
        check("rst_pwrite",  64'(bus.pwrite), 64'd0);
        check("rst_pwdata",  64'(bus.pwdata), 64'd0);
        check("rst_rsp_vld", 64'(rsp_valid), 64'd0);
        check("rst_rdata",   64'(rsp_rdata), 64'd0);
        check("rst_rsp_wr",  64'(rsp_write), 64'd0);
        check("rst_req_rdy", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Directed read from slave 3, then directed write to slave 15
        slv_data[3] = 64'hDEAD_BEEF_0123_4567;
        xfer(32'h0000_3010, 1'b0, 64'h0, 1'b0);
        check("read_rdata_lit", 64'(rsp_rdata), 64'hDEAD_BEEF_0123_4567);
        req_valid = 1'b0;
        @(negedge clk);
        check("consumed", 64'(rsp_valid), 64'd0);
        xfer(32'h0000_F000, 1'b1, 64'h55AA, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);

        // Back-to-back with req_valid held high
        for (int k = 0; k < 4; k++)
            xfer($urandom, 1'($urandom), {$urandom, $urandom}, k > 0);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_drained", 64'(rsp_valid), 64'd0);

        // Back-pressure: response held for 5 cycles, request waiting
        rsp_ready = 1'b0;
        a = $urandom;
        xfer(a, 1'b0, 64'h0, 1'b0);
        bp_data   = slv_data[a[DL +: 4]];
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_rdy", 64'(req_ready), 64'd0);
            check("bp_rsp_vld", 64'(rsp_valid), 64'd1);
            check("bp_rdata",   64'(rsp_rdata), 64'(bp_data));
            check("bp_pselx",   64'(bus.pselx), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        xfer($urandom, 1'b1, {$urandom, $urandom}, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset during ACCESS discards the transfer
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_penable", 64'(bus.penable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_pselx",   64'(bus.pselx), 64'd0);
        check("abort_penable", 64'(bus.penable), 64'd0);
        check("abort_rsp_vld", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // Decode sweep over all 16 slaves with randomised other bits
        for (int i = 0; i < DN; i++) begin
            a = $urandom;
            a[DL +: 4] = i[3:0];
            xfer(a, 1'($urandom), {$urandom, $urandom}, 1'b0);
            req_valid = 1'b0;
            @(negedge clk);
        end

        // Random traffic with idle gaps
        for (int i = 0; i < 12; i++) begin
            xfer($urandom, 1'($urandom), {$urandom, $urandom}, 1'b0);
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
